// File: rtl/dsp_mac_sequencer_pkg.sv
// Shared widths, slice opcodes and sequencer state encoding for the MAC sequencer.
package dsp_mac_sequencer_pkg;
  localparam int A_W   = 18;
  localparam int P_W   = 48;
  localparam int OP_W  = 8;
  localparam int CNT_W = 11;

  localparam logic [OP_W-1:0] OP_ZERO = 8'h00;
  localparam logic [OP_W-1:0] OP_LOAD = 8'h01;
  localparam logic [OP_W-1:0] OP_HOLD = 8'h08;
  localparam logic [OP_W-1:0] OP_ACC  = 8'h09;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2,
    ST_HOLD  = 2'd3
  } state_t;
endpackage

// File: rtl/dsp_mac_sequencer_tag.sv
// Resettable tag delay line; DEPTH of 0 collapses to a plain wire.
module dsp_tag_delay #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);
  generate
    if (DEPTH == 0) begin : g_wire
      logic unused_clk_rst;
      assign unused_clk_rst = clk ^ rst_n;
      assign q = d;
    end else begin : g_pipe
      logic [DEPTH-1:0][WIDTH-1:0] pipe;
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          pipe <= '0;
        end else begin
          pipe[0] <= d;
          for (int i = 1; i < DEPTH; i++) pipe[i] <= pipe[i-1];
        end
      end
      assign q = pipe[DEPTH-1];
    end
  endgenerate
endmodule

// File: rtl/dsp_mac_sequencer.sv
// Streams packets of unsigned 18x18 operand pairs into a pipelined DSP slice and
// returns one accumulated 48-bit sum per packet over a valid/ready result port.
module dsp_mac_sequencer
  import dsp_mac_sequencer_pkg::*;
#(
  parameter int LATENCY    = 3,
  parameter int OPMODE_DLY = 1,
  parameter int MAX_LEN    = 1024
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             s_valid,
  output logic             s_ready,
  input  logic [A_W-1:0]   s_a,
  input  logic [A_W-1:0]   s_b,
  input  logic             s_last,
  output logic [A_W-1:0]   dsp_a,
  output logic [A_W-1:0]   dsp_b,
  output logic [A_W-1:0]   dsp_d,
  output logic [P_W-1:0]   dsp_c,
  output logic [OP_W-1:0]  dsp_opmode,
  input  logic [P_W-1:0]   dsp_p,
  input  logic             dsp_carryout,
  output logic             m_valid,
  input  logic             m_ready,
  output logic [P_W-1:0]   m_data,
  output logic             m_carry,
  output logic [CNT_W-1:0] m_count,
  output logic             m_err
);
  localparam int DW = (LATENCY < 1) ? 1 : $clog2(LATENCY + 1);

  state_t            state;
  logic [OP_W-1:0]   issue_tag;
  logic [DW-1:0]     drain_cnt;
  logic              accept;
  logic              acc_at_adder;
  logic [CNT_W-1:0]  cnt_inc;

  assign accept  = s_valid & s_ready;
  assign cnt_inc = m_count + CNT_W'(1);
  assign dsp_c   = '0;
  assign dsp_d   = '0;

  dsp_tag_delay #(.WIDTH(OP_W), .DEPTH(OPMODE_DLY)) u_opmode_dly (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (issue_tag),
    .q     (dsp_opmode)
  );

  // Marks the cycles in which an accumulate result (and its carry) leaves the slice.
  dsp_tag_delay #(.WIDTH(1), .DEPTH(LATENCY)) u_adder_dly (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (issue_tag == OP_ACC),
    .q     (acc_at_adder)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      s_ready   <= 1'b0;
      m_valid   <= 1'b0;
      m_data    <= '0;
      m_carry   <= 1'b0;
      m_count   <= '0;
      m_err     <= 1'b0;
      dsp_a     <= '0;
      dsp_b     <= '0;
      issue_tag <= OP_ZERO;
      drain_cnt <= '0;
    end else begin
      dsp_a <= accept ? s_a : '0;
      dsp_b <= accept ? s_b : '0;
      if (acc_at_adder && dsp_carryout) m_carry <= 1'b1;
      unique case (state)
        ST_IDLE: begin
          issue_tag <= OP_ZERO;
          s_ready   <= 1'b1;
          if (accept) begin
            issue_tag <= OP_LOAD;
            m_count   <= CNT_W'(1);
            m_carry   <= 1'b0;
            m_err     <= (MAX_LEN == 1) && !s_last;
            if (s_last || MAX_LEN == 1) begin
              state     <= ST_DRAIN;
              s_ready   <= 1'b0;
              drain_cnt <= '0;
            end else begin
              state <= ST_RUN;
            end
          end
        end
        ST_RUN: begin
          issue_tag <= OP_HOLD;
          if (accept) begin
            issue_tag <= OP_ACC;
            m_count   <= cnt_inc;
            if (s_last || cnt_inc == CNT_W'(MAX_LEN)) begin
              state     <= ST_DRAIN;
              s_ready   <= 1'b0;
              drain_cnt <= '0;
              m_err     <= !s_last;
            end
          end
        end
        // First DRAIN cycle carries the closing beat; its sum is on dsp_p LATENCY cycles later.
        ST_DRAIN: begin
          issue_tag <= OP_HOLD;
          drain_cnt <= drain_cnt + DW'(1);
          if (drain_cnt == DW'(LATENCY)) begin
            state     <= ST_HOLD;
            issue_tag <= OP_ZERO;
            m_data    <= dsp_p;
            m_valid   <= 1'b1;
          end
        end
        ST_HOLD: begin
          issue_tag <= OP_ZERO;
          if (m_ready) begin
            m_valid <= 1'b0;
            s_ready <= 1'b1;
            state   <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_dsp_mac_sequencer.sv
// Randomized and directed checks of the MAC sequencer against a packet-level model
// and a 3-cycle DSP slice model with a one-cycle opmode trail.
module tb_dsp_mac_sequencer;
  localparam int LAT  = 3;
  localparam int OD   = 1;
  localparam int MAXL = 4;

  logic        clk = 1'b0, rst_n = 1'b0;
  logic        s_valid = 1'b0, s_ready, s_last = 1'b0;
  logic [17:0] s_a = '0, s_b = '0, dsp_a, dsp_b, dsp_d;
  logic [47:0] dsp_c, dsp_p = '0, m_data;
  logic [7:0]  dsp_opmode;
  logic        dsp_carryout = 1'b0;
  logic        m_valid, m_ready, m_carry, m_err;
  logic [10:0] m_count;

  bit rand_rdy = 0, rdy_dir = 1, rnd_rdy = 1, inj_carry = 0;
  int n_cmp = 0, n_bad = 0;

  typedef struct packed { logic [47:0] d; logic [10:0] c; logic e; logic cy; } res_t;
  res_t sbq[$];
  logic [17:0] pa[0:7];
  logic [17:0] pb[0:7];

  int n_results = 0, op01 = 0, op08 = 0, op09 = 0;
  logic [47:0] last_data = '0;
  logic [10:0] last_count = '0;
  logic        last_err = 1'b0, last_carry = 1'b0;

  dsp_mac_sequencer #(.LATENCY(LAT), .OPMODE_DLY(OD), .MAX_LEN(MAXL)) u_dut (
    .clk(clk), .rst_n(rst_n), .s_valid(s_valid), .s_ready(s_ready), .s_a(s_a), .s_b(s_b),
    .s_last(s_last), .dsp_a(dsp_a), .dsp_b(dsp_b), .dsp_d(dsp_d), .dsp_c(dsp_c),
    .dsp_opmode(dsp_opmode), .dsp_p(dsp_p), .dsp_carryout(dsp_carryout), .m_valid(m_valid),
    .m_ready(m_ready), .m_data(m_data), .m_carry(m_carry), .m_count(m_count), .m_err(m_err)
  );

  always #5 clk = ~clk;
  assign m_ready = rand_rdy ? rnd_rdy : rdy_dir;
  always @(posedge clk) begin #1; rnd_rdy = ($urandom_range(0, 3) != 0); end

  // DSP slice model: product pipeline of LAT-1 stages, opmode realigned by LAT-1-OD stages.
  logic [47:0] pr1 = '0, pr2 = '0;
  logic [7:0]  opd = '0;
  logic [48:0] acc_sum;
  assign acc_sum = {1'b0, dsp_p} + {1'b0, pr2};
  always @(posedge clk) begin
    pr1 <= 48'(dsp_a) * 48'(dsp_b);
    pr2 <= pr1;
    opd <= dsp_opmode;
    case (opd)
      8'h01:   begin dsp_p <= pr2; dsp_carryout <= 1'b0; end
      8'h09:   begin dsp_p <= acc_sum[47:0]; dsp_carryout <= acc_sum[48] | inj_carry; end
      default: dsp_carryout <= 1'b0;
    endcase
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s t=%0t got %0h expected %0h", nm, $time, act, exp);
    end
  endtask

  task automatic timeout(input string nm);
    n_cmp++; n_bad++;
    $display("FAIL %s t=%0t got timeout expected event", nm, $time);
  endtask

  // Packet-phase model: 0 collecting beats, 1 draining, 2 holding a result.
  int ph = 0, mcnt = 0, dleft = 0;
  logic [47:0] msum = '0;
  bit merr = 0, e_ready = 0, e_mvalid = 0, e_err = 0, e_cy = 0, acc;
  logic [17:0] e_a = '0, e_b = '0;
  logic [7:0]  e_op = '0, ntag;
  logic [47:0] e_data = '0;
  int e_cnt = 0;
  logic [7:0] tq[$];
  res_t r;

  always @(negedge clk) begin
    if (!rst_n) begin
      chk("rst_s_ready", 64'(s_ready), 0);   chk("rst_m_valid", 64'(m_valid), 0);
      chk("rst_dsp_a", 64'(dsp_a), 0);       chk("rst_dsp_b", 64'(dsp_b), 0);
      chk("rst_opmode", 64'(dsp_opmode), 0); chk("rst_m_data", 64'(m_data), 0);
      chk("rst_m_count", 64'(m_count), 0);   chk("rst_m_err", 64'(m_err), 0);
      chk("rst_m_carry", 64'(m_carry), 0);
      ph = 0; mcnt = 0; e_ready = 0; e_mvalid = 0; e_a = '0; e_b = '0; e_op = '0;
      tq.delete();
    end else begin
      chk("s_ready", 64'(s_ready), 64'(e_ready));
      chk("m_valid", 64'(m_valid), 64'(e_mvalid));
      chk("dsp_a", 64'(dsp_a), 64'(e_a));
      chk("dsp_b", 64'(dsp_b), 64'(e_b));
      chk("dsp_opmode", 64'(dsp_opmode), 64'(e_op));
      chk("dsp_cd_zero", 64'(dsp_c) | 64'(dsp_d), 0);
      if (e_mvalid) begin
        chk("m_data", 64'(m_data), 64'(e_data));
        chk("m_count", 64'(m_count), 64'(e_cnt));
        chk("m_err", 64'(m_err), 64'(e_err));
        chk("m_carry", 64'(m_carry), 64'(e_cy));
      end
      if (dsp_opmode == 8'h01) op01++;
      if (dsp_opmode == 8'h08) op08++;
      if (dsp_opmode == 8'h09) op09++;
      if (m_valid && m_ready) begin
        if (sbq.size() == 0) begin
          timeout("unexpected_result");
        end else begin
          r = sbq.pop_front();
          chk("sb_data", 64'(m_data), 64'(r.d));
          chk("sb_count", 64'(m_count), 64'(r.c));
          chk("sb_err", 64'(m_err), 64'(r.e));
          chk("sb_carry", 64'(m_carry), 64'(r.cy));
        end
        last_data = m_data; last_count = m_count; last_err = m_err; last_carry = m_carry;
        n_results++;
      end
      // advance to the next cycle
      acc  = s_valid && e_ready;
      e_a  = acc ? s_a : '0;
      e_b  = acc ? s_b : '0;
      ntag = 8'h00;
      case (ph)
        0: if (acc) begin
             ntag = (mcnt == 0) ? 8'h01 : 8'h09;
             msum = ((mcnt == 0) ? 48'd0 : msum) + 48'(s_a) * 48'(s_b);
             mcnt++;
             if (s_last || mcnt == MAXL) begin ph = 1; dleft = LAT + 1; merr = !s_last; end
           end else begin
             ntag = (mcnt == 0) ? 8'h00 : 8'h08;
           end
        1: begin
             dleft--;
             if (dleft == 0) begin
               ph = 2;
               e_data = msum; e_cnt = mcnt; e_err = merr; e_cy = inj_carry && (mcnt > 1);
             end else begin
               ntag = 8'h08;
             end
           end
        default: if (m_ready) begin ph = 0; mcnt = 0; end
      endcase
      e_ready  = (ph == 0);
      e_mvalid = (ph == 2);
      tq.push_back(ntag);
      if (tq.size() > OD + 1) void'(tq.pop_front());
      e_op = (tq.size() > OD) ? tq[tq.size() - 1 - OD] : 8'h00;
    end
  end

  task automatic wait_accept();
    bit got = 0;
    for (int k = 0; k < 200 && !got; k++) begin
      @(negedge clk);
      got = s_ready;
    end
    if (!got) timeout("accept_wait");
    @(posedge clk); #1;
  endtask

  task automatic send_pkt(input int n, input bit with_last, input int gap);
    res_t x;
    x.d = '0;
    for (int i = 0; i < n; i++) x.d += 48'(pa[i]) * 48'(pb[i]);
    x.c = 11'(n); x.e = !with_last; x.cy = inj_carry && (n > 1);
    sbq.push_back(x);
    for (int i = 0; i < n; i++) begin
      s_valid = 1; s_a = pa[i]; s_b = pb[i]; s_last = with_last && (i == n - 1);
      wait_accept();
      s_valid = 0; s_last = 0; s_a = '0; s_b = '0;
      repeat ((gap < 0) ? int'($urandom_range(0, 2)) : gap) begin @(posedge clk); #1; end
    end
  endtask

  task automatic wait_result(input string nm);
    int start = n_results;
    int k = 0;
    while (n_results == start && k < 300) begin @(posedge clk); k++; end
    if (n_results == start) timeout(nm);
    #1;
  endtask

  task automatic load_abc();
    pa[0] = 18'd2; pb[0] = 18'd3; pa[1] = 18'd4; pb[1] = 18'd5; pa[2] = 18'd6; pb[2] = 18'd7;
  endtask

  initial begin
    int s01, s08, s09, start;
    bit seen;
    repeat (3) @(posedge clk);
    #1 rst_n = 1;
    repeat (2) @(posedge clk);
    #1;
    // basic three-beat packet
    load_abc();
    send_pkt(3, 1, 0);
    wait_result("t1_result");
    chk("t1_data", 64'(last_data), 64'd68);  chk("t1_count", 64'(last_count), 3);
    chk("t1_err", 64'(last_err), 0);         chk("t1_carry", 64'(last_carry), 0);
    // single full-scale beat
    s01 = op01; s09 = op09;
    pa[0] = 18'h3FFFF; pb[0] = 18'h3FFFF;
    send_pkt(1, 1, 0);
    wait_result("t2_result");
    chk("t2_data", 64'(last_data), 64'hF_FFF8_0001); chk("t2_count", 64'(last_count), 1);
    chk("t2_op01", 64'(op01 - s01), 1);             chk("t2_op09", 64'(op09 - s09), 0);
    // two-cycle valid gaps between beats
    s08 = op08;
    load_abc();
    send_pkt(3, 1, 2);
    wait_result("t3_result");
    chk("t3_data", 64'(last_data), 64'd68);
    chk("t3_op08", 64'(op08 - s08), 7);
    // result held under backpressure
    rdy_dir = 0;
    load_abc();
    send_pkt(3, 1, 0);
    seen = 0;
    for (int k = 0; k < 100 && !seen; k++) begin @(negedge clk); seen = m_valid; end
    if (!seen) timeout("t4_valid");
    for (int k = 0; k < 5; k++) begin
      chk("t4_hold_valid", 64'(m_valid), 1);
      chk("t4_hold_data", 64'(m_data), 64'd68);
      chk("t4_hold_ready", 64'(s_ready), 0);
      @(negedge clk);
    end
    @(posedge clk); #1 rdy_dir = 1;
    wait_result("t4_result");
    chk("t4_data", 64'(last_data), 64'd68);
    // reset in the middle of a packet
    load_abc();
    for (int i = 0; i < 2; i++) begin
      s_valid = 1; s_a = pa[i]; s_b = pb[i];
      wait_accept();
      s_valid = 0; s_a = '0; s_b = '0;
    end
    start = n_results;
    rst_n = 0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1;
    repeat (10) @(posedge clk);
    #1;
    chk("t5_no_result", 64'(n_results), 64'(start));
    pa[0] = 18'd5; pb[0] = 18'd5;
    send_pkt(1, 1, 0);
    wait_result("t5_result");
    chk("t5_data", 64'(last_data), 64'd25);
    // MAX_LEN termination
    for (int i = 0; i < 4; i++) begin pa[i] = 18'd1; pb[i] = 18'd1; end
    send_pkt(4, 0, 0);
    wait_result("t6_result");
    chk("t6_data", 64'(last_data), 64'd4); chk("t6_count", 64'(last_count), 4);
    chk("t6_err", 64'(last_err), 1);
    // sticky carry counts only accumulate cycles
    inj_carry = 1;
    load_abc();
    send_pkt(2, 1, 0);
    wait_result("t7_result");
    chk("t7_carry", 64'(last_carry), 1);
    send_pkt(1, 1, 0);
    wait_result("t7b_result");
    chk("t7b_carry", 64'(last_carry), 0);
    inj_carry = 0;
    // randomized packets with random gaps and result backpressure
    rand_rdy = 1;
    for (int p = 0; p < 150; p++) begin
      int n;
      bit wl;
      n  = int'($urandom_range(1, MAXL));
      wl = (n < MAXL) ? 1'b1 : 1'($urandom_range(0, 1));
      for (int i = 0; i < n; i++) begin
        pa[i] = 18'($urandom_range(0, 18'h3FFFF));
        pb[i] = 18'($urandom_range(0, 18'h3FFFF));
      end
      send_pkt(n, wl, -1);
    end
    rand_rdy = 0; rdy_dir = 1;
    for (int k = 0; k < 300 && sbq.size() != 0; k++) @(posedge clk);
    #1;
    chk("sb_drained", 64'(sbq.size()), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog t=%0t got no finish expected finish", $time);
    $fatal(1);
  end
endmodule
